// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
// Tags are held zero-extended to 32 bits so one entry type fits every geometry.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } state_e;

    typedef enum logic {
        SRC_CPU,
        SRC_SB
    } src_e;

    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [31:0] tag;
    } tag_entry_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int line_words);
        return 32 - idx_w(sets) - off_w(line_words);
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: tag/state entry and data line per set.
// Writes are synchronous, reads are combinational from the presented index.
module dcache_way_array
    import dcache_pkg::*;
#(
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [$clog2(SETS)-1:0]       index,
    input  logic                          tag_we,
    input  tag_entry_t                    tag_wdata,
    input  logic                          data_we,
    input  logic [32*LINE_WORDS-1:0]      line_wdata,
    input  logic                          word_we,
    input  logic [$clog2(LINE_WORDS)-1:0] word_sel,
    input  logic [31:0]                   word_wdata,
    output tag_entry_t                    entry,
    output logic [32*LINE_WORDS-1:0]      line
);

    tag_entry_t                 tags [SETS];
    logic [32*LINE_WORDS-1:0]   data [SETS];

    // Only the state bits need reset; stale tags are masked by valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                tags[s].valid <= 1'b0;
                tags[s].dirty <= 1'b0;
            end
        end else if (tag_we) begin
            tags[index] <= tag_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (data_we) begin
            data[index] <= line_wdata;
        end else if (word_we) begin
            data[index][32*word_sel +: 32] <= word_wdata;
        end
    end

    assign entry = tags[index];
    assign line  = data[index];

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// N-way set-associative write-back L1 data cache controller with true LRU.
// Serves MEM-stage loads/store probes and store-buffer drains, one at a time.
module dcache_assoc_ctrl
    import dcache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req_valid,
    input  logic                    cpu_req_rw,
    input  logic [31:0]             cpu_req_addr,
    output logic                    cpu_res_ready,
    output logic [31:0]             cpu_res_data,
    input  logic                    sb_drain_valid,
    input  logic [31:0]             sb_drain_addr,
    input  logic [31:0]             sb_drain_data,
    output logic                    sb_drain_done,
    input  logic                    force_drain,
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [31:0]             mem_req_addr,
    output logic [32*LINE_WORDS-1:0] mem_req_data,
    input  logic                    mem_ready,
    input  logic [32*LINE_WORDS-1:0] mem_rdata,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(SETS, LINE_WORDS);
    localparam int WSEL_W = OFF_W - 2;
    localparam int WAY_W  = clog2_min1(WAYS);
    localparam int LINE_W = 32 * LINE_WORDS;

    state_e state, state_n;

    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic              req_rw;
    src_e              req_src;
    logic [WAY_W-1:0]  victim;
    logic              missed;

    logic [IDX_W-1:0]  req_index;
    logic [WSEL_W-1:0] req_wsel;
    logic [31:0]       req_tag;

    tag_entry_t        way_entry [WAYS];
    logic [LINE_W-1:0] way_line  [WAYS];

    logic [WAYS-1:0]   tag_we;
    logic [WAYS-1:0]   data_we;
    logic [WAYS-1:0]   word_we;
    tag_entry_t        tag_wdata;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  oldest;
    logic [WAY_W-1:0]  vict_sel;
    logic              found_inv;

    logic              take;
    src_e              take_src;
    logic              set_victim;
    logic              hit_inc;
    logic              miss_inc;
    logic              lru_upd;

    assign req_index = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_wsel  = req_addr[OFF_W-1:2];
    assign req_tag   = req_addr >> (OFF_W + IDX_W);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_way_array #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS)
        ) u_way (
            .clock      (clock),
            .reset      (reset),
            .index      (req_index),
            .tag_we     (tag_we[w]),
            .tag_wdata  (tag_wdata),
            .data_we    (data_we[w]),
            .line_wdata (mem_rdata),
            .word_we    (word_we[w]),
            .word_sel   (req_wsel),
            .word_wdata (req_data),
            .entry      (way_entry[w]),
            .line       (way_line[w])
        );
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_entry[w].valid && way_entry[w].tag == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Fill holes first; only a full set falls back to the LRU way.
    always_comb begin
        vict_sel  = '0;
        found_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_inv && !way_entry[w].valid) begin
                found_inv = 1'b1;
                vict_sel  = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            vict_sel = oldest;
        end
    end

    if (WAYS > 1) begin : g_lru
        logic [WAY_W-1:0] age [SETS][WAYS];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        age[s][w] <= WAY_W'(w);
                    end
                end
            end else if (lru_upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way) begin
                        age[req_index][w] <= '0;
                    end else if (age[req_index][w] < age[req_index][hit_way]) begin
                        age[req_index][w] <= age[req_index][w] + WAY_W'(1);
                    end
                end
            end
        end

        // Ages form a permutation, so the oldest way holds WAYS-1.
        always_comb begin
            oldest = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (age[req_index][w] == WAY_W'(WAYS - 1)) begin
                    oldest = WAY_W'(w);
                end
            end
        end
    end else begin : g_no_lru
        assign oldest = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_data   <= '0;
            req_rw     <= 1'b0;
            req_src    <= SRC_CPU;
            victim     <= '0;
            missed     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                req_src <= take_src;
                missed  <= 1'b0;
                if (take_src == SRC_CPU) begin
                    req_addr <= cpu_req_addr;
                    req_data <= '0;
                    req_rw   <= cpu_req_rw;
                end else begin
                    req_addr <= sb_drain_addr;
                    req_data <= sb_drain_data;
                    req_rw   <= 1'b1;
                end
            end
            if (set_victim) begin
                victim <= vict_sel;
                missed <= 1'b1;
            end
            if (hit_inc) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_inc) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n       = state;
        take          = 1'b0;
        take_src      = SRC_CPU;
        set_victim    = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        lru_upd       = 1'b0;
        tag_we        = '0;
        data_we       = '0;
        word_we       = '0;
        tag_wdata     = '0;
        cpu_res_ready = 1'b0;
        cpu_res_data  = '0;
        sb_drain_done = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        unique case (state)
            IDLE: begin
                if (cpu_req_valid && !force_drain) begin
                    take     = 1'b1;
                    take_src = SRC_CPU;
                    state_n  = COMPARE;
                end else if (sb_drain_valid) begin
                    take     = 1'b1;
                    take_src = SRC_SB;
                    state_n  = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    // A post-fill re-compare was already counted as a miss.
                    hit_inc         = !missed;
                    lru_upd         = 1'b1;
                    state_n         = IDLE;
                    tag_wdata       = way_entry[hit_way];
                    tag_wdata.dirty = 1'b1;
                    if (req_src == SRC_SB) begin
                        word_we[hit_way] = 1'b1;
                        tag_we[hit_way]  = 1'b1;
                        sb_drain_done    = 1'b1;
                    end else begin
                        tag_we[hit_way] = req_rw;
                        cpu_res_ready   = 1'b1;
                        cpu_res_data    = way_line[hit_way][32*req_wsel +: 32];
                    end
                end else begin
                    miss_inc   = !missed;
                    set_victim = 1'b1;
                    if (way_entry[vict_sel].valid && way_entry[vict_sel].dirty) begin
                        state_n = WRITE_BACK;
                    end else begin
                        state_n = ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {way_entry[victim].tag[TAG_W-1:0], req_index, {OFF_W{1'b0}}};
                mem_req_data  = way_line[victim];
                if (mem_ready) begin
                    tag_wdata       = way_entry[victim];
                    tag_wdata.dirty = 1'b0;
                    tag_we[victim]  = 1'b1;
                    state_n         = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag[TAG_W-1:0], req_index, {OFF_W{1'b0}}};
                if (mem_ready) begin
                    tag_wdata.valid = 1'b1;
                    tag_wdata.dirty = 1'b0;
                    tag_wdata.tag   = req_tag;
                    tag_we[victim]  = 1'b1;
                    data_we[victim] = 1'b1;
                    state_n         = COMPARE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// Directed bench for dcache_assoc_ctrl with response and memory scoreboards.
// Expected responses and memory requests are queued by stimulus, popped by monitors.
module tb_dcache_assoc_ctrl;

    localparam int LW      = 128;
    localparam int MEM_LAT = 3;

    logic           clock = 1'b0;
    logic           reset;
    logic           cpu_req_valid;
    logic           cpu_req_rw;
    logic [31:0]    cpu_req_addr;
    logic           cpu_res_ready;
    logic [31:0]    cpu_res_data;
    logic           sb_drain_valid;
    logic [31:0]    sb_drain_addr;
    logic [31:0]    sb_drain_data;
    logic           sb_drain_done;
    logic           force_drain;
    logic           mem_req_valid;
    logic           mem_req_rw;
    logic [31:0]    mem_req_addr;
    logic [LW-1:0]  mem_req_data;
    logic           mem_ready;
    logic [LW-1:0]  mem_rdata;
    logic [31:0]    hit_count;
    logic [31:0]    miss_count;

    always #5 clock = ~clock;

    dcache_assoc_ctrl #(
        .WAYS       (2),
        .SETS       (4),
        .LINE_WORDS (4),
        .CNT_W      (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_res_ready  (cpu_res_ready),
        .cpu_res_data   (cpu_res_data),
        .sb_drain_valid (sb_drain_valid),
        .sb_drain_addr  (sb_drain_addr),
        .sb_drain_data  (sb_drain_data),
        .sb_drain_done  (sb_drain_done),
        .force_drain    (force_drain),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    typedef struct {
        logic        is_sb;
        logic        chk;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic          rw;
        logic [31:0]   addr;
        logic [LW-1:0] data;
    } mreq_t;

    resp_t       exp_resp [$];
    mreq_t       exp_mem  [$];
    logic [31:0] mem_words [int unsigned];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_resp_cyc = 0;
    int unsigned last_mready_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return 32'h1000_0000 | a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_cpu(input logic chk, input logic [31:0] d);
        resp_t e;
        e.is_sb = 1'b0;
        e.chk   = chk;
        e.data  = d;
        exp_resp.push_back(e);
    endtask

    task automatic expect_sb();
        resp_t e;
        e.is_sb = 1'b1;
        e.chk   = 1'b0;
        e.data  = '0;
        exp_resp.push_back(e);
    endtask

    task automatic expect_mem(input logic rw, input logic [31:0] a, input logic [LW-1:0] d);
        mreq_t m;
        m.rw   = rw;
        m.addr = a;
        m.data = d;
        exp_mem.push_back(m);
    endtask

    // Response monitor
    resp_t mon_e;
    always @(negedge clock) begin
        if (!reset && (cpu_res_ready || sb_drain_done)) begin
            checks++;
            last_resp_cyc = cyc;
            if (cpu_res_ready && sb_drain_done) begin
                errors++;
                $display("FAIL resp_both_pulses cpu=%b sb=%b", cpu_res_ready, sb_drain_done);
            end else if (exp_resp.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected cpu=%b sb=%b", cpu_res_ready, sb_drain_done);
            end else begin
                mon_e = exp_resp.pop_front();
                if (mon_e.is_sb != sb_drain_done) begin
                    errors++;
                    $display("FAIL resp_order got_sb=%b required_sb=%b", sb_drain_done, mon_e.is_sb);
                end else if (!mon_e.is_sb && mon_e.chk && cpu_res_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL resp_data actual=%h required=%h", cpu_res_data, mon_e.data);
                end
            end
        end
    end

    // Memory model and request monitor; a request dropped mid-wait is abandoned.
    initial begin : mem_model
        mreq_t m;
        bit    alive;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (mem_req_valid) begin
                alive = 1'b1;
                for (int i = 0; i < MEM_LAT; i++) begin
                    @(negedge clock);
                    if (!mem_req_valid) begin
                        alive = 1'b0;
                        break;
                    end
                end
                if (alive) begin
                    checks++;
                    if (exp_mem.size() == 0) begin
                        errors++;
                        $display("FAIL mem_unexpected rw=%b addr=%h", mem_req_rw, mem_req_addr);
                    end else begin
                        m = exp_mem.pop_front();
                        if (mem_req_rw !== m.rw || mem_req_addr !== m.addr ||
                            (m.rw && mem_req_data !== m.data)) begin
                            errors++;
                            $display("FAIL mem_req actual=%b/%h/%h required=%b/%h/%h",
                                     mem_req_rw, mem_req_addr, mem_req_data,
                                     m.rw, m.addr, m.data);
                        end
                    end
                    for (int w = 0; w < 4; w++) begin
                        if (mem_req_rw) mem_words[mem_req_addr + 4*w] = mem_req_data[32*w +: 32];
                        else mem_rdata[32*w +: 32] = rd_word(mem_req_addr + 4*w);
                    end
                    @(posedge clock);
                    #1 mem_ready = 1'b1;
                    last_mready_cyc = cyc;
                    @(posedge clock);
                    #1 mem_ready = 1'b0;
                end
            end
        end
    end

    task automatic cpu_op(input logic rw, input logic [31:0] addr, output int lat);
        @(posedge clock);
        #1;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!cpu_res_ready && lat < 200);
        if (!cpu_res_ready) begin
            checks++;
            errors++;
            $display("FAIL cpu_timeout addr=%h waited=%0d", addr, lat);
        end
        @(posedge clock);
        #1 cpu_req_valid = 1'b0;
    endtask

    task automatic sb_op(input logic [31:0] addr, input logic [31:0] d, input logic frc);
        int n;
        @(posedge clock);
        #1;
        sb_drain_valid = 1'b1;
        sb_drain_addr  = addr;
        sb_drain_data  = d;
        force_drain    = frc;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sb_drain_done && n < 200);
        if (!sb_drain_done) begin
            checks++;
            errors++;
            $display("FAIL sb_timeout addr=%h waited=%0d", addr, n);
        end
        @(posedge clock);
        #1;
        sb_drain_valid = 1'b0;
        force_drain    = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int n;
        reset          = 1'b1;
        cpu_req_valid  = 1'b0;
        cpu_req_rw     = 1'b0;
        cpu_req_addr   = '0;
        sb_drain_valid = 1'b0;
        sb_drain_addr  = '0;
        sb_drain_data  = '0;
        force_drain    = 1'b0;
        mem_words[32'h108] = 32'hA5A5_A5A5;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_cpu_res_ready", 32'(cpu_res_ready), 0);
        check("rst_sb_drain_done", 32'(sb_drain_done), 0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);

        // Cold load miss
        expect_mem(1'b0, 32'h100, '0);
        expect_cpu(1'b1, 32'hA5A5_A5A5);
        cpu_op(1'b0, 32'h108, lat);
        check("t1_miss_count", miss_count, 1);
        check("t1_hit_count", hit_count, 0);
        check("t1_resp_after_mem_ready",
              32'((last_resp_cyc - last_mready_cyc >= 1) && (last_resp_cyc - last_mready_cyc <= 2)), 1);

        // Two lines in set 0, then a hit
        expect_mem(1'b0, 32'h000, '0);
        expect_cpu(1'b1, 32'h1000_0000);
        cpu_op(1'b0, 32'h000, lat);
        expect_mem(1'b0, 32'h040, '0);
        expect_cpu(1'b1, 32'h1000_0040);
        cpu_op(1'b0, 32'h040, lat);
        expect_cpu(1'b1, 32'h1000_0000);
        cpu_op(1'b0, 32'h000, lat);
        check("t2_hit_latency", lat, 2);
        check("t2_hit_count", hit_count, 1);
        check("t2_miss_count", miss_count, 3);

        // Dirty LRU victim is written back
        expect_sb();
        sb_op(32'h040, 32'hDEAD_BEEF, 1'b0);
        expect_cpu(1'b1, 32'h1000_0000);
        cpu_op(1'b0, 32'h000, lat);
        expect_mem(1'b1, 32'h040, {32'h1000_004C, 32'h1000_0048, 32'h1000_0044, 32'hDEAD_BEEF});
        expect_mem(1'b0, 32'h080, '0);
        expect_cpu(1'b1, 32'h1000_0080);
        cpu_op(1'b0, 32'h080, lat);
        expect_cpu(1'b1, 32'h1000_0000);
        cpu_op(1'b0, 32'h000, lat);
        check("t3_resident_hit_latency", lat, 2);
        expect_mem(1'b0, 32'h040, '0);
        expect_cpu(1'b1, 32'hDEAD_BEEF);
        cpu_op(1'b0, 32'h040, lat);
        check("t3_hit_count", hit_count, 4);
        check("t3_miss_count", miss_count, 5);

        // Arbitration, CPU first then SB priority
        expect_cpu(1'b1, 32'h1000_0000);
        expect_sb();
        fork
            cpu_op(1'b0, 32'h000, lat);
            sb_op(32'h004, 32'h1111_1111, 1'b0);
        join
        expect_sb();
        expect_cpu(1'b1, 32'h1111_1111);
        fork
            cpu_op(1'b0, 32'h004, lat);
            sb_op(32'h008, 32'h2222_2222, 1'b1);
        join
        check("t4_hit_count", hit_count, 8);

        // Store probe allocates dirty; later evicted by write-back
        expect_mem(1'b0, 32'h310, '0);
        expect_cpu(1'b0, '0);
        cpu_op(1'b1, 32'h310, lat);
        expect_mem(1'b0, 32'h350, '0);
        expect_cpu(1'b1, 32'h1000_0350);
        cpu_op(1'b0, 32'h350, lat);
        expect_mem(1'b1, 32'h310, {32'h1000_031C, 32'h1000_0318, 32'h1000_0314, 32'h1000_0310});
        expect_mem(1'b0, 32'h390, '0);
        expect_cpu(1'b1, 32'h1000_0390);
        cpu_op(1'b0, 32'h390, lat);
        check("t4b_miss_count", miss_count, 8);

        // Reset during ALLOCATE
        @(posedge clock);
        #1;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 32'h108;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mem_req_valid && n < 50);
        check("t6_alloc_seen", 32'(mem_req_valid), 1);
        @(posedge clock);
        #1;
        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("t6_mem_req_valid_dropped", 32'(mem_req_valid), 0);
        check("t6_hit_count_cleared", hit_count, 0);
        check("t6_miss_count_cleared", miss_count, 0);
        check("t6_cpu_res_ready_low", 32'(cpu_res_ready), 0);
        reset = 1'b0;
        expect_mem(1'b0, 32'h100, '0);
        expect_cpu(1'b1, 32'hA5A5_A5A5);
        cpu_op(1'b0, 32'h108, lat);
        check("t6_reload_miss_count", miss_count, 1);

        // Drain miss allocates, then load hits the drained word
        expect_mem(1'b0, 32'h200, '0);
        expect_sb();
        sb_op(32'h204, 32'h1234_5678, 1'b0);
        check("t5_miss_count", miss_count, 2);
        expect_cpu(1'b1, 32'h1234_5678);
        cpu_op(1'b0, 32'h204, lat);
        check("t5_hit_latency", lat, 2);
        check("t5_hit_count", hit_count, 1);

        repeat (4) @(posedge clock);
        check("resp_queue_drained", exp_resp.size(), 0);
        check("mem_queue_drained", exp_mem.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
